// File: rtl/bresenham_circle_plotter.sv
// Midpoint/Bresenham circle rasteriser: walks one octant and emits eight mirrored
// candidate pixels per step over a valid/ready stream, clipping off-screen points.
module bresenham_circle_plotter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] cx,
  input  logic [8:0] cy,
  input  logic [8:0] radius,
  output logic       idle,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, PLOT, STEP, DONE} state_t;

  localparam logic signed [11:0] H_LIM = 12'(H_RES);
  localparam logic signed [11:0] V_LIM = 12'(V_RES);

  state_t state_reg, state_next;
  logic [9:0]         cx_reg, cx_next;
  logic [8:0]         cy_reg, cy_next;
  logic signed [11:0] x_reg, x_next;
  logic signed [11:0] y_reg, y_next;
  logic signed [13:0] d_reg, d_next;
  logic [2:0]         oct_reg, oct_next;

  logic signed [11:0] cx_ext, cy_ext, a_off, b_off, cand_x, cand_y;
  logic signed [11:0] x_upd, y_upd;
  logic signed [13:0] x_ext, y_ext;
  logic               in_bounds;

  // oct[2] swaps the roles of x/y, oct[0] mirrors X, oct[1] mirrors Y.
  assign cx_ext    = {2'b00, cx_reg};
  assign cy_ext    = {3'b000, cy_reg};
  assign a_off     = oct_reg[2] ? y_reg : x_reg;
  assign b_off     = oct_reg[2] ? x_reg : y_reg;
  assign cand_x    = oct_reg[0] ? (cx_ext - a_off) : (cx_ext + a_off);
  assign cand_y    = oct_reg[1] ? (cy_ext - b_off) : (cy_ext + b_off);
  assign in_bounds = (cand_x >= 12'sd0) && (cand_x < H_LIM) &&
                     (cand_y >= 12'sd0) && (cand_y < V_LIM);

  assign x_ext = {{2{x_reg[11]}}, x_reg};
  assign y_ext = {{2{y_reg[11]}}, y_reg};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cx_reg    <= '0;
      cy_reg    <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      d_reg     <= '0;
      oct_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      d_reg     <= d_next;
      oct_reg   <= oct_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cx_next    = cx_reg;
    cy_next    = cy_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    d_next     = d_reg;
    oct_next   = oct_reg;
    idle       = 1'b0;
    pix_valid  = 1'b0;
    pix_x      = '0;
    pix_y      = '0;
    done       = 1'b0;
    x_upd      = x_reg + 12'sd1;
    y_upd      = y_reg;

    case (state_reg)
      IDLE: begin
        idle = 1'b1;
        if (start) begin
          cx_next    = cx;
          cy_next    = cy;
          x_next     = '0;
          y_next     = {3'b000, radius};
          d_next     = 14'sd3 - $signed({4'b0000, radius, 1'b0});
          oct_next   = '0;
          state_next = PLOT;
        end
      end
      PLOT: begin
        // pix_valid depends only on registered state, never on pix_ready.
        if (in_bounds) begin
          pix_valid = 1'b1;
          pix_x     = cand_x[9:0];
          pix_y     = cand_y[8:0];
        end
        if (!in_bounds || pix_ready) begin
          oct_next = oct_reg + 3'd1;
          if (oct_reg == 3'd7)
            state_next = STEP;
        end
      end
      STEP: begin
        if (d_reg < 14'sd0) begin
          d_next = d_reg + (x_ext <<< 2) + 14'sd6;
        end else begin
          d_next = d_reg + ((x_ext - y_ext) <<< 2) + 14'sd10;
          y_upd  = y_reg - 12'sd1;
        end
        x_next     = x_upd;
        y_next     = y_upd;
        oct_next   = '0;
        state_next = (x_upd > y_upd) ? DONE : PLOT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bresenham_circle_plotter.sv
// Self-checking bench for bresenham_circle_plotter: directed and randomized circles
// compared against a queue of expected pixels computed with plain integer arithmetic.
module tb_bresenham_circle_plotter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] cx;
  logic [8:0] cy;
  logic [8:0] radius;
  logic       idle;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       done;

  int n_checks;
  int n_fail;

  bresenham_circle_plotter #(.H_RES(640), .V_RES(480)) dut (
    .clk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy), .radius(radius),
    .idle(idle), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // mode 0: ready always high, 1: random ready + stray start pulses, 2: 5-cycle stall
  task automatic run_circle(input int ccx, input int ccy, input int r,
                            input int mode, input bit check_timing);
    int exp_x[$];
    int exp_y[$];
    int mx, my, md, it, k, px, py, bad_stab, n_extra, ex, ey;
    bit prev_stall, got_done;

    mx = 0; my = r; md = 3 - 2 * r; it = 0;
    do begin
      for (int o = 0; o < 8; o++) begin
        int a, b, xx, yy;
        a  = (o >= 4) ? my : mx;
        b  = (o >= 4) ? mx : my;
        xx = (o % 2 == 1) ? ccx - a : ccx + a;
        yy = ((o / 2) % 2 == 1) ? ccy - b : ccy + b;
        if (xx >= 0 && xx < 640 && yy >= 0 && yy < 480) begin
          exp_x.push_back(xx);
          exp_y.push_back(yy);
        end
      end
      if (md < 0) md += 4 * mx + 6;
      else begin
        md += 4 * (mx - my) + 10;
        my--;
      end
      mx++;
      it++;
    end while (mx <= my);

    check("idle_before_start", int'(idle), 1);
    cx = 10'(ccx); cy = 9'(ccy); radius = 9'(r); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cx = 10'($urandom); cy = 9'($urandom); radius = 9'($urandom);
    k = 1; got_done = 0; prev_stall = 0; bad_stab = 0; n_extra = 0; px = 0; py = 0;
    while (k < 20000) begin
      case (mode)
        0: pix_ready = 1'b1;
        1: pix_ready = 1'($urandom);
        default: pix_ready = (k >= 6 && k < 11) ? 1'b0 : 1'b1;
      endcase
      if (mode == 1) start = 1'($urandom);
      #1;
      if (prev_stall && !(pix_valid && int'(pix_x) == px && int'(pix_y) == py)) bad_stab++;
      prev_stall = pix_valid && !pix_ready;
      px = int'(pix_x);
      py = int'(pix_y);
      if (pix_valid && pix_ready) begin
        if (exp_x.size() == 0) n_extra++;
        else begin
          ex = exp_x.pop_front();
          ey = exp_y.pop_front();
          check("pix_x", int'(pix_x), ex);
          check("pix_y", int'(pix_y), ey);
        end
      end
      if (done) begin
        got_done = 1;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    pix_ready = 1'b1;
    check("done_seen", int'(got_done), 1);
    check("pixels_missing", exp_x.size(), 0);
    check("pixels_extra", n_extra, 0);
    check("stall_stability", bad_stab, 0);
    if (check_timing) check("done_cycle", k, it * 9 + 1);
    @(posedge clk); #2;
    check("idle_after_done", int'(idle), 1);
    check("done_single_cycle", int'(done), 0);
    $display("circle c=(%0d,%0d) r=%0d mode=%0d iterations=%0d cycles=%0d", ccx, ccy, r, mode, it, k);
  endtask

  initial begin
    int viol;
    n_checks = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; pix_ready = 1'b0;
    cx = '0; cy = '0; radius = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset_idle", int'(idle), 1);
    check("reset_pix_valid", int'(pix_valid), 0);
    check("reset_done", int'(done), 0);
    check("reset_pix_x", int'(pix_x), 0);
    check("reset_pix_y", int'(pix_y), 0);
    @(posedge clk); #1;

    run_circle(320, 240, 0, 0, 1);
    run_circle(10, 10, 1, 0, 1);
    run_circle(0, 0, 1, 0, 1);
    run_circle(100, 100, 3, 2, 0);
    run_circle(50, 60, 3, 0, 1);
    run_circle(639, 479, 511, 0, 1);
    for (int i = 0; i < 6; i++)
      run_circle(int'($urandom_range(700, 0)), int'($urandom_range(511, 0)),
                 int'($urandom_range(60, 0)), 1, 0);

    // reset in the middle of a circle
    cx = 10'd200; cy = 9'd200; radius = 9'd50; pix_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midreset_pix_valid", int'(pix_valid), 0);
    check("midreset_idle", int'(idle), 1);
    check("midreset_done", int'(done), 0);
    check("midreset_pix_x", int'(pix_x), 0);
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if (pix_valid || done || !idle) viol++;
    end
    check("midreset_quiet", viol, 0);
    $display("reset mid-circle checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
